dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DBITS, default 32, data and address width.
REQ-002 Parameter LOCK_MAX, default 8, maximum consecutive grants to one locked requester.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 req0, req1  input  1 each  request from CPU load/store port (0) or I/O-poll/debug port (1).
REQ-006 we0, we1  input  1 each  write-enable qualifier of the request.
REQ-007 lock0, lock1  input  1 each  requester keeps bus for back-to-back transactions.
REQ-008 addr0, addr1  input  DBITS each  byte address.
REQ-009 wdata0, wdata1  input  DBITS each  write data.
REQ-010 gnt0, gnt1  output  1 each  one-cycle pulse: request issued to memory this cycle.
REQ-011 rvalid0, rvalid1  output  1 each  one-cycle pulse: read data valid.
REQ-012 rdata0, rdata1  output  DBITS each  read data.
REQ-013 mem_we  output  1; mem_addr  output  DBITS; mem_wdata  output  DBITS  to single-port data memory / MMIO.
REQ-014 mem_rdata  input  DBITS  memory read data, valid exactly one cycle after issue.

Function
REQ-015 Block SHALL share one data memory port between two requesters; at most one issue per cycle.
REQ-016 Issue SHALL be combinational from the registered arbitration state: mem_* SHALL carry the winner's we/addr/wdata in the gnt cycle; mem_we=0, mem_addr=0, mem_wdata=0 when no grant.
REQ-017 A requester SHALL hold req/we/addr/wdata stable until it sees its gnt; it SHALL drop or change them the cycle after gnt.
REQ-018 Arbitration: single requester wins; both requesting -> the one not granted last (round-robin pointer last_gnt).
REQ-019 last_gnt SHALL update to the winner on every grant.
REQ-020 FSM states: IDLE, OWN0, OWN1; OWNx entered when requester x is granted with lockx=1; IDLE otherwise.
REQ-021 In OWNx only requester x SHALL be granted; the other requester waits regardless of round-robin.
REQ-022 A 4-bit-minimum counter lock_cnt SHALL count grants in OWNx; OWNx -> IDLE when lockx=0, reqx=0 for one cycle, or lock_cnt reaches LOCK_MAX; the forced release SHALL set last_gnt=x so the other requester wins next if pending.
REQ-023 Read return: a registered rd_owner (none/0/1) SHALL tag each read issue; next cycle rvalid of that owner=1 and rdatax=mem_rdata; rdata of the non-owner SHALL be 0.
REQ-024 Writes SHALL produce no rvalid.
REQ-025 Back-to-back reads SHALL be supported: issue N+1 overlaps return of N; throughput one transaction/cycle.
REQ-026 Simultaneous req0 and req1 from IDLE immediately after reset: requester 0 SHALL win.
REQ-027 Request withdrawn before gnt (protocol violation): arbiter SHALL simply not grant it; no state corruption.

Reset
REQ-028 On reset=0 (asynchronous): state=IDLE, last_gnt=1, lock_cnt=0, rd_owner=none; gnt*, rvalid*, mem_we = 0; rdata*, mem_addr, mem_wdata = 0.
REQ-029 Reset asserted mid-transaction SHALL discard any pending read return; no rvalid after reset release until a new read issue.
REQ-030 First grant possible in the first clk edge after reset deasserts.

Structure
REQ-031 FSM state encoding, rd_owner encoding, and the MMIO base addresses (KEY 0xF0000010, SW 0xF0000014, HEX 0xF0000000, LEDR 0xF0000004, LEDG 0xF0000008) SHALL live in the shared project package.
REQ-032 One sub-module, rr_arb2 (2-way round-robin priority pick from req vector and last_gnt), SHALL be used; the remainder stays flat.

Verification
REQ-033 Reset then req0=req1=1 read, addr0=0x40, addr1=0x80, mem_rdata echoes addr -> gnt0 cycle 1, gnt1 cycle 2, rvalid0 rdata0=0x40 cycle 2, rvalid1 rdata1=0x80 cycle 3.
REQ-034 req0 write addr 0xF0000004 data 0x3FF, req1 idle -> single gnt0, mem_we=1, mem_addr=0xF0000004, mem_wdata=0x3FF, no rvalid.
REQ-035 lock1=1, req1 held 12 cycles, req0 held -> exactly 8 gnt1 pulses, then gnt0, then no gnt1 until the cycle after gnt0.
REQ-036 Continuous reads both ports for 20 cycles without lock -> gnt alternates 0,1,0,1; every read returns exactly one rvalid to the correct owner.
REQ-037 Read issued, reset pulsed low before the return cycle -> no rvalid; all outputs 0 during reset.
REQ-038 lock0=1 then lock0 drops after 3 grants with req1 pending -> state IDLE, gnt1 on the next cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared arbitration state, read-owner encodings and MMIO base addresses
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_0, RD_1} rd_owner_t;
  localparam logic [31:0] MMIO_HEX  = 32'hF000_0000;
  localparam logic [31:0] MMIO_LEDR = 32'hF000_0004;
  localparam logic [31:0] MMIO_LEDG = 32'hF000_0008;
  localparam logic [31:0] MMIO_KEY  = 32'hF000_0010;
  localparam logic [31:0] MMIO_SW   = 32'hF000_0014;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; req[1:0] requests, last_gnt index of previous winner, gnt[1:0] one-hot pick
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last_gnt);
  assign gnt[1] = req[1] & (~req[0] | ~last_gnt);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between two requesters with round-robin, locking and read return
// Ports: clk, reset (async active-low); per requester x: reqx/wex/lockx/addrx/wdatax in, gntx/rvalidx/rdatax out;
//        mem_we/mem_addr/mem_wdata to memory, mem_rdata from memory (valid one cycle after issue).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             lock0,
  input  logic             lock1,
  input  logic [DBITS-1:0] addr0,
  input  logic [DBITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata0,
  input  logic [DBITS-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DBITS-1:0] rdata0,
  output logic [DBITS-1:0] rdata1,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata
);
  localparam int CW = $clog2(LOCK_MAX + 1) > 4 ? $clog2(LOCK_MAX + 1) : 4;
  state_t         state, state_nx;
  rd_owner_t      rd_owner, rd_owner_nx;
  logic           last_gnt, last_gnt_nx;
  logic [CW-1:0]  lock_cnt, lock_cnt_nx;
  logic [1:0]     rr_gnt, gnt;
  logic           own_req, own_lock;
  rr_arb2 u_rr (.req({req1, req0}), .last_gnt(last_gnt), .gnt(rr_gnt));
  // reset also gates the combinational issue path so every output reads 0 while held
  assign gnt = !reset ? 2'b00 : state == OWN0 ? {1'b0, req0} : state == OWN1 ? {req1, 1'b0} : rr_gnt;
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign mem_we    = gnt[0] ? we0 : gnt[1] & we1;
  assign mem_addr  = gnt[0] ? addr0 : gnt[1] ? addr1 : '0;
  assign mem_wdata = gnt[0] ? wdata0 : gnt[1] ? wdata1 : '0;
  assign rvalid0 = rd_owner == RD_0;
  assign rvalid1 = rd_owner == RD_1;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;
  assign own_req  = state == OWN1 ? req1 : req0;
  assign own_lock = state == OWN1 ? lock1 : lock0;
  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    lock_cnt_nx = lock_cnt;
    rd_owner_nx = RD_NONE;
    if (|gnt) begin
      last_gnt_nx = gnt[1];
      rd_owner_nx = mem_we ? RD_NONE : gnt[1] ? RD_1 : RD_0;
    end
    case (state)
      OWN0, OWN1: begin
        // lock_cnt already includes the grant that opened the session
        if (!own_req || !own_lock || lock_cnt >= CW'(LOCK_MAX - 1)) begin
          state_nx    = IDLE;
          lock_cnt_nx = '0;
          last_gnt_nx = state == OWN1;
        end else begin
          lock_cnt_nx = lock_cnt + 1'b1;
        end
      end
      default: begin
        if (|gnt && (gnt[1] ? lock1 : lock0) && LOCK_MAX > 1) begin
          state_nx    = gnt[1] ? OWN1 : OWN0;
          lock_cnt_nx = CW'(1);
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
      rd_owner <= RD_NONE;
    end else begin
      state    <= state_nx;
      last_gnt <= last_gnt_nx;
      lock_cnt <= lock_cnt_nx;
      rd_owner <= rd_owner_nx;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a session-level reference model
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;
  localparam int DBITS = 32;
  localparam int LOCK_MAX = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic r[2], w[2], l[2];
  logic [DBITS-1:0] a[2], d[2];
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DBITS-1:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [DBITS-1:0] mem_rdata = '0;
  logic obs_g0, obs_g1;
  int n_chk = 0;
  int n_fail = 0;
  int m_owner, m_cnt, m_last, m_ret;
  logic [DBITS-1:0] m_retd;
  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem_addr;
  dmem_arbiter #(.DBITS(DBITS), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(r[0]), .req1(r[1]), .we0(w[0]), .we1(w[1]), .lock0(l[0]), .lock1(l[1]),
    .addr0(a[0]), .addr1(a[1]), .wdata0(d[0]), .wdata1(d[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic m_reset();
    m_owner = -1;
    m_cnt = 0;
    m_last = 1;
    m_ret = -1;
    m_retd = '0;
  endtask
  task automatic tick(output int win);
    logic ew;
    logic [DBITS-1:0] ea, ed;
    @(negedge clk);
    if (m_owner >= 0) win = r[m_owner] ? m_owner : -1;
    else if (r[0] && r[1]) win = 1 - m_last;
    else win = r[0] ? 0 : r[1] ? 1 : -1;
    ew = 1'b0;
    ea = '0;
    ed = '0;
    if (win >= 0) begin
      ew = w[win];
      ea = a[win];
      ed = d[win];
    end
    obs_g0 = gnt0;
    obs_g1 = gnt1;
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("mem_we", mem_we, ew);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("rvalid0", rvalid0, m_ret == 0);
    chk("rvalid1", rvalid1, m_ret == 1);
    chk("rdata0", rdata0, m_ret == 0 ? m_retd : '0);
    chk("rdata1", rdata1, m_ret == 1 ? m_retd : '0);
    @(posedge clk);
    m_ret = -1;
    if (win >= 0) begin
      m_last = win;
      if (!ew) begin
        m_ret = win;
        m_retd = ea;
      end
    end
    if (m_owner >= 0) begin
      if (win == m_owner && l[win] && m_cnt + 1 < LOCK_MAX) m_cnt++;
      else begin
        m_owner = -1;
        m_cnt = 0;
      end
    end else if (win >= 0 && l[win] && LOCK_MAX > 1) begin
      m_owner = win;
      m_cnt = 1;
    end
    #1;
  endtask
  task automatic new_req(input int p);
    r[p] = $urandom_range(0, 3) != 0;
    w[p] = 1'($urandom_range(0, 1));
    l[p] = $urandom_range(0, 3) == 0;
    a[p] = $urandom;
    d[p] = $urandom;
  endtask
  task automatic idle_all();
    for (int p = 0; p < 2; p++) begin
      r[p] = 0;
      w[p] = 0;
      l[p] = 0;
    end
  endtask
  initial begin
    int win, g1cnt;
    bit seen0;
    idle_all();
    m_reset();
    r[0] = 1; r[1] = 1;
    a[0] = 32'h40; a[1] = 32'h80;
    d[0] = '0; d[1] = '0;
    #12;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid0", rvalid0, 0);
    @(posedge clk);
    #1 reset = 1;
    tick(win); r[0] = 0;
    tick(win); r[1] = 0;
    tick(win);
    r[0] = 1; w[0] = 1; a[0] = MMIO_LEDR; d[0] = 32'h3FF;
    tick(win); r[0] = 0; w[0] = 0;
    tick(win);
    tick(win);
    r[1] = 1; l[1] = 1; a[1] = 32'h200;
    tick(win);
    g1cnt = obs_g1;
    r[0] = 1; a[0] = 32'h300;
    seen0 = 0;
    for (int i = 0; i < 12 && !seen0; i++) begin
      a[1] = a[1] + 4;
      tick(win);
      if (obs_g0) seen0 = 1;
      else g1cnt += obs_g1;
    end
    chk("lock_burst_gnt1", g1cnt, LOCK_MAX);
    chk("lock_release_gnt0", seen0, 1);
    r[0] = 0;
    tick(win);
    chk("after_release_gnt1", obs_g1, 1);
    idle_all();
    tick(win);
    tick(win);
    r[0] = 1; r[1] = 1;
    for (int i = 0; i < 20; i++) begin
      tick(win);
      if (win >= 0) a[win] = $urandom;
    end
    idle_all();
    tick(win);
    tick(win);
    r[0] = 1; l[0] = 1; a[0] = 32'h500;
    tick(win);
    r[1] = 1; a[1] = 32'h600;
    tick(win);
    tick(win);
    l[0] = 0; r[0] = 0;
    tick(win);
    tick(win);
    chk("lock_drop_gnt1", obs_g1, 1);
    idle_all();
    tick(win);
    tick(win);
    r[0] = 1; a[0] = 32'h123;
    @(negedge clk);
    chk("pre_reset_gnt0", gnt0, 1);
    reset = 0;
    #1;
    chk("mid_rst_gnt0", gnt0, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_rvalid0", rvalid0, 0);
    chk("mid_rst_rdata0", rdata0, 0);
    r[0] = 0;
    m_reset();
    reset = 1;
    tick(win);
    tick(win);
    new_req(0);
    new_req(1);
    for (int i = 0; i < 400; i++) begin
      tick(win);
      for (int p = 0; p < 2; p++) begin
        if (win == p || !r[p]) new_req(p);
        else if ($urandom_range(0, 19) == 0) r[p] = 0;
      end
    end
    idle_all();
    tick(win);
    tick(win);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
